muldiv_unit: RTL

Multi-cycle multiply/divide unit with HI/LO registers for the MIPS core, parametrised in data width. It sits beside the single-cycle ALU in the execute stage. It decodes the R-type funct codes for mult/multu/div/divu/mthi/mtlo and runs an iterative sequencer. It exposes a start/busy/done handshake so the pipeline can stall while an operation is in flight.

---
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Iterative radix-2 shift-add multiply and restoring divide, WIDTH+1 cycle latency.
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiply with a
// single-cycle combinational product (divide stays iterative).
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // {upper, lower}: product, or {remainder, quotient}
    logic [WIDTH-1:0]   mcand_q, mcand_d; // multiplicand magnitude or divisor magnitude
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               neg_q, neg_d;     // product / quotient sign
    logic               rneg_q, rneg_d;   // remainder sign (dividend sign)
    logic               ismul_q, ismul_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    // Funct decode
    logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
    assign is_mult  = (funct == 6'b011000);
    assign is_multu = (funct == 6'b011001);
    assign is_div   = (funct == 6'b011010);
    assign is_divu  = (funct == 6'b011011);
    assign is_mthi  = (funct == 6'b010001);
    assign is_mtlo  = (funct == 6'b010011);

    // Operand magnitudes; a zero divisor forces unsigned handling so the plain
    // restoring loop yields quotient = all ones and remainder = raw dividend.
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign signed_op = is_mult | (is_div & (b != '0));
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One shift-add multiply step: add multiplicand if LSB set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step: shift in next dividend bit, trial-subtract divisor.
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] mul_res, mul_fix;
    logic [1:0]         mul_entry;
`ifdef MULDIV_FAST_MUL_EN
    assign mul_res   = (2*WIDTH)'(mcand_q) * (2*WIDTH)'(acc_q[WIDTH-1:0]);
    assign mul_entry = StFix;
`else
    assign mul_res   = acc_q;
    assign mul_entry = StMul;
`endif
    assign mul_fix = neg_q ? -mul_res : mul_res;

    logic last_iter;
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    // Next-state logic for the sequencer and HI/LO
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        ismul_d = ismul_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mthi) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (is_mtlo) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end else if (is_mult || is_multu) begin
                        mcand_d = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        ismul_d = 1'b1;
                        cnt_d   = '0;
                        state_d = mul_entry;
                    end else if (is_div || is_divu) begin
                        mcand_d = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        ismul_d = 1'b0;
                        cnt_d   = '0;
                        state_d = StDiv;
                    end
                end
            end
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) state_d = StFix;
            end
            StDiv: begin
                acc_d = div_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) state_d = StFix;
            end
            default: begin // StFix
                if (ismul_q) begin
                    {hi_d, lo_d} = mul_fix;
                end else begin
                    lo_d = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
        endcase
        // Abort discards the partial result; start wins while idle.
        if (flush && state_q != StIdle) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            ismul_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            ismul_q <= ismul_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
